// File: rtl/airlock_pkg.sv
// Shared types and default sizing for the airlock pressure controller.
package airlock_pkg;

  localparam int PRESS_W_DEF   = 8;
  localparam int PRESS_MAX_DEF = 200;
  localparam int STEP_DEF      = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAC  = 2'd1,
    ST_PRESS = 2'd2,
    ST_FAULT = 2'd3
  } air_state_e;

  // Chamber is sealed only when both doors report closed.
  function automatic logic sealed_f(input logic inner_closed, input logic outer_closed);
    return inner_closed & outer_closed;
  endfunction

endpackage

// File: rtl/pressure_counter.sv
// Saturating up/down pressure register: clamps at max going up and at zero going down.
module pressure_counter
  import airlock_pkg::*;
#(
  parameter int             W       = PRESS_W_DEF,
  parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] step,
  input  logic [W-1:0] max,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  // Next value: compare before the add/subtract so the arithmetic never wraps.
  always_comb begin
    value_d = value_q;
    if (inc && !dec) begin
      if (value_q >= (max - step)) begin
        value_d = max;
      end else begin
        value_d = value_q + step;
      end
    end else if (dec && !inc) begin
      if (value_q <= step) begin
        value_d = {W{1'b0}};
      end else begin
        value_d = value_q - step;
      end
    end else begin
      value_d = value_q;
    end
  end

  // Pressure state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= RST_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/airlock_pressure_ctrl.sv
// Airlock controller: sequences evacuation/pressurization with door interlock,
// abort and latched fault handling.
module airlock_pressure_ctrl
  import airlock_pkg::*;
#(
  parameter int PRESS_W   = PRESS_W_DEF,
  parameter int PRESS_MAX = PRESS_MAX_DEF,
  parameter int STEP      = STEP_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               begin_Evacuation,
  input  logic               begin_Pressurization,
  input  logic               InnerClosed,
  input  logic               OuterClosed,
  input  logic               abort,
  input  logic               fault_clear,
  output logic               Evacuation,
  output logic               Pressurization,
  output logic               Evacuated,
  output logic               Pressurized,
  output logic [PRESS_W-1:0] Pressure,
  output logic               done,
  output logic               Fault
);

  localparam logic [PRESS_W-1:0] MAX_V  = PRESS_W'(PRESS_MAX);
  localparam logic [PRESS_W-1:0] STEP_V = PRESS_W'(STEP);

  air_state_e state_q;
  air_state_e state_d;
  logic       done_q;
  logic       done_d;
  logic       sealed_s;
  logic       inc_s;
  logic       dec_s;
  logic       evac_hit_s;
  logic       press_hit_s;

  assign sealed_s    = sealed_f(InnerClosed, OuterClosed);
  // True when the step about to be applied lands exactly on the target.
  assign evac_hit_s  = (Pressure <= STEP_V);
  assign press_hit_s = (Pressure >= (MAX_V - STEP_V));

  // Next-state, counter enables and completion pulse.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    inc_s   = 1'b0;
    dec_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (begin_Evacuation && !begin_Pressurization && sealed_s && !Evacuated) begin
          state_d = ST_EVAC;
        end else if (begin_Pressurization && !begin_Evacuation && sealed_s && !Pressurized) begin
          state_d = ST_PRESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EVAC: begin
        if (!sealed_s) begin
          state_d = ST_FAULT;
        end else if (abort) begin
          state_d = ST_IDLE;
        end else begin
          dec_s = 1'b1;
          if (evac_hit_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_EVAC;
          end
        end
      end
      ST_PRESS: begin
        if (!sealed_s) begin
          state_d = ST_FAULT;
        end else if (abort) begin
          state_d = ST_IDLE;
        end else begin
          inc_s = 1'b1;
          if (press_hit_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PRESS;
          end
        end
      end
      ST_FAULT: begin
        if (fault_clear && sealed_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and done pulse registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  pressure_counter #(
    .W       (PRESS_W),
    .RST_VAL (MAX_V)
  ) u_pressure_counter (
    .clk   (Clock),
    .rst   (Reset),
    .inc   (inc_s),
    .dec   (dec_s),
    .step  (STEP_V),
    .max   (MAX_V),
    .value (Pressure)
  );

  assign Evacuation     = (state_q == ST_EVAC);
  assign Pressurization = (state_q == ST_PRESS);
  assign Fault          = (state_q == ST_FAULT);
  assign Evacuated      = (Pressure == {PRESS_W{1'b0}});
  assign Pressurized    = (Pressure == MAX_V);
  assign done           = done_q;

endmodule

// File: tb/tb_airlock_pressure_ctrl.sv
// Bench for airlock_pressure_ctrl: vector table, directed corner sequences and
// random traffic against a behavioural model of the airlock rules.
module tb_airlock_pressure_ctrl;

  localparam int PMAX = 200;
  localparam int STP  = 5;
  localparam int M_IDLE = 0, M_EVAC = 1, M_PRESS = 2, M_FAULT = 3;

  logic       Clock;
  logic       Reset;
  logic       be, bp, ic, oc, ab, fc;
  logic       ev, pr, evd, prd, dn, ft;
  logic [7:0] p;
  logic       ev7, pr7, evd7, prd7, dn7, ft7;
  logic [7:0] p7;

  int n_vec = 0;
  int n_err = 0;

  int   m_mode;
  int   m_p;
  logic m_done;

  airlock_pressure_ctrl dut (
    .Clock(Clock), .Reset(Reset), .begin_Evacuation(be), .begin_Pressurization(bp),
    .InnerClosed(ic), .OuterClosed(oc), .abort(ab), .fault_clear(fc),
    .Evacuation(ev), .Pressurization(pr), .Evacuated(evd), .Pressurized(prd),
    .Pressure(p), .done(dn), .Fault(ft)
  );

  airlock_pressure_ctrl #(.STEP(7)) dut7 (
    .Clock(Clock), .Reset(Reset), .begin_Evacuation(be), .begin_Pressurization(bp),
    .InnerClosed(ic), .OuterClosed(oc), .abort(ab), .fault_clear(fc),
    .Evacuation(ev7), .Pressurization(pr7), .Evacuated(evd7), .Pressurized(prd7),
    .Pressure(p7), .done(dn7), .Fault(ft7)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic be, bp, ic, oc, ab, fc;
    logic ev, pr, dn, ft;
    logic [7:0] p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] dut_vec();
    return {ev, pr, evd, prd, dn, ft, p};
  endfunction

  function automatic logic [13:0] model_vec();
    return {m_mode == M_EVAC, m_mode == M_PRESS, m_p == 0, m_p == PMAX,
            m_done, m_mode == M_FAULT, 8'(m_p)};
  endfunction

  function automatic logic [13:0] exp_vec(input vec_t v);
    return {v.ev, v.pr, v.p == 8'd0, v.p == 8'(PMAX), v.dn, v.ft, v.p};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_p    = PMAX;
    m_done = 1'b0;
  endtask

  // Airlock rules evaluated on the input values present at a rising edge.
  task automatic model_step();
    bit sealed;
    sealed = ic && oc;
    m_done = 1'b0;
    if (m_mode == M_IDLE) begin
      if (be && !bp && sealed && m_p != 0) m_mode = M_EVAC;
      else if (bp && !be && sealed && m_p != PMAX) m_mode = M_PRESS;
    end else if (m_mode == M_EVAC || m_mode == M_PRESS) begin
      if (!sealed) m_mode = M_FAULT;
      else if (ab) m_mode = M_IDLE;
      else if (m_mode == M_EVAC) begin
        m_p = (m_p - STP < 0) ? 0 : m_p - STP;
        if (m_p == 0) begin m_mode = M_IDLE; m_done = 1'b1; end
      end else begin
        m_p = (m_p + STP > PMAX) ? PMAX : m_p + STP;
        if (m_p == PMAX) begin m_mode = M_IDLE; m_done = 1'b1; end
      end
    end else begin
      if (fc && sealed) m_mode = M_IDLE;
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    model_step();
    #1;
    check("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic do_reset();
    be = 1'b0; bp = 1'b0; ic = 1'b1; oc = 1'b1; ab = 1'b0; fc = 1'b0;
    Reset = 1'b1;
    #2;
    model_reset();
    check("reset", 32'(dut_vec()), 32'(model_vec()));
    check("reset7", 32'({ev7, pr7, evd7, prd7, dn7, ft7, p7}), 32'({6'b000100, 8'd200}));
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic wait_p(input int target, input int bound);
    int k;
    k = 0;
    while (p != 8'(target) && k < bound) begin
      cyc();
      k++;
    end
    check("wait_pressure", 32'(p), 32'(target));
  endtask

  vec_t tbl[15];

  initial begin
    int cnt, dcnt, wraps, last_nz, prev;
    bit hit;
    Reset = 1'b1;
    be = 1'b0; bp = 1'b0; ic = 1'b1; oc = 1'b1; ab = 1'b0; fc = 1'b0;

    //            be   bp   ic   oc   ab   fc   ev   pr   dn   ft   p
    tbl[0]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd200};
    tbl[1]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd200};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd200};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd200};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'd200};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'd195};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'd195};
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'd195};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'd200};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'd200};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'd200};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,8'd200};
    tbl[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'd200};
    tbl[13] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'd200};
    tbl[14] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'd200};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      be = tbl[i].be; bp = tbl[i].bp; ic = tbl[i].ic;
      oc = tbl[i].oc; ab = tbl[i].ab; fc = tbl[i].fc;
      cyc();
      check($sformatf("table[%0d]", i), 32'(dut_vec()), 32'(exp_vec(tbl[i])));
    end

    // Full evacuation from a one-cycle request.
    do_reset();
    be = 1'b1; cyc(); be = 1'b0;
    cnt = ev ? 1 : 0; dcnt = 0; hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      cyc();
      if (ev) cnt++;
      if (dn) begin dcnt++; hit = 1'b1; end
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (dn) dcnt++;
    end
    check("evac_done_seen", 32'(hit), 32'd1);
    check("evac_active_cycles", 32'(cnt), 32'd40);
    check("evac_done_pulses", 32'(dcnt), 32'd1);
    check("evac_final", 32'({evd, p}), 32'({1'b1, 8'd0}));

    // STEP=7 instance: last step saturates from 4, no wrap.
    do_reset();
    be = 1'b1; cyc(); be = 1'b0;
    cnt = ev7 ? 1 : 0; wraps = 0; last_nz = -1; prev = int'(p7); hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      cyc();
      if (ev7) cnt++;
      if (int'(p7) > prev) wraps++;
      if (p7 != 8'd0) last_nz = int'(p7);
      prev = int'(p7);
      if (dn7) hit = 1'b1;
    end
    check("step7_active_cycles", 32'(cnt), 32'd29);
    check("step7_last_nonzero", 32'(last_nz), 32'd4);
    check("step7_final", 32'(p7), 32'd0);
    check("step7_wraps", 32'(wraps), 32'd0);

    // Door loss mid-evacuation, fault hold and clear.
    do_reset();
    be = 1'b1; cyc(); be = 1'b0;
    wait_p(120, 50);
    oc = 1'b0; cyc();
    check("door_fault", 32'({ft, p}), 32'({1'b1, 8'd120}));
    fc = 1'b1; cyc();
    check("clear_while_open", 32'({ft, p}), 32'({1'b1, 8'd120}));
    oc = 1'b1; cyc(); fc = 1'b0;
    check("clear_sealed", 32'({ft, ev, pr, p}), 32'({3'b000, 8'd120}));

    // Abort mid-pressurization, then resume.
    be = 1'b1; cyc(); be = 1'b0;
    wait_p(0, 60);
    cyc();
    bp = 1'b1; cyc(); bp = 1'b0;
    wait_p(100, 40);
    ab = 1'b1; cyc(); ab = 1'b0;
    check("abort", 32'({pr, dn, p}), 32'({2'b00, 8'd100}));
    cyc();
    check("abort_no_done", 32'({dn, p}), 32'({1'b0, 8'd100}));
    bp = 1'b1; cyc(); bp = 1'b0;
    cnt = 0; hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      cyc();
      cnt++;
      if (dn) hit = 1'b1;
    end
    check("resume_cycles", 32'(cnt), 32'd20);
    check("resume_final", 32'({prd, p}), 32'({1'b1, 8'd200}));

    // Asynchronous reset mid-evacuation.
    do_reset();
    be = 1'b1; cyc(); be = 1'b0;
    wait_p(50, 60);
    #2 Reset = 1'b1;
    #1;
    check("async_reset", 32'(dut_vec()), 32'({6'b000100, 8'd200}));
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (dn) dcnt++;
    end
    check("reset_no_done", 32'(dcnt), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      ic = ($urandom_range(0, 15) != 0);
      oc = ($urandom_range(0, 15) != 0);
      be = ($urandom_range(0, 3) == 0);
      bp = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 31) == 0);
      fc = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/airlock_pressure_ctrl.md
AIRLOCK_PRESSURE_CTRL -- requirements
Module: airlock_pressure_ctrl

Interface
REQ-001 The block SHALL have parameter PRESS_W, default 8: width of the chamber pressure value.
REQ-002 The block SHALL have parameter PRESS_MAX, default 200: full-atmosphere pressure value, with 1 <= PRESS_MAX <= 2**PRESS_W-1.
REQ-003 The block SHALL have parameter STEP, default 5: pressure change per active cycle, with 1 <= STEP <= PRESS_MAX.
REQ-004 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port begin_Evacuation, input, 1 bit: evacuation request level.
REQ-007 The block SHALL have port begin_Pressurization, input, 1 bit: pressurization request level.
REQ-008 The block SHALL have ports InnerClosed and OuterClosed, inputs, 1 bit each: door-closed status (1 = closed).
REQ-009 The block SHALL have port abort, input, 1 bit: stops the active operation and holds pressure.
REQ-010 The block SHALL have port fault_clear, input, 1 bit: requests exit from FAULT.
REQ-011 The block SHALL have port Evacuation, output, 1 bit: pump on; 1 iff state is EVAC.
REQ-012 The block SHALL have port Pressurization, output, 1 bit: fill valve open; 1 iff state is PRESS.
REQ-013 The block SHALL have port Evacuated, output, 1 bit: 1 iff Pressure == 0.
REQ-014 The block SHALL have port Pressurized, output, 1 bit: 1 iff Pressure == PRESS_MAX.
REQ-015 The block SHALL have port Pressure, output, PRESS_W bits: current chamber pressure, registered.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse when an operation completes normally.
REQ-017 The block SHALL have port Fault, output, 1 bit: 1 iff state is FAULT.

Function
REQ-018 The FSM SHALL have four states: IDLE, EVAC, PRESS, FAULT; "sealed" means InnerClosed && OuterClosed.
REQ-019 In IDLE, when begin_Evacuation && !begin_Pressurization && sealed && !Evacuated, the next state SHALL be EVAC.
REQ-020 In IDLE, when begin_Pressurization && !begin_Evacuation && sealed && !Pressurized, the next state SHALL be PRESS.
REQ-021 When both requests are asserted in IDLE, or a request arrives while not sealed or already at its target, the FSM SHALL stay in IDLE; no fault is raised.
REQ-022 On each edge in EVAC with sealed && !abort, Pressure SHALL become max(Pressure-STEP, 0) and SHALL saturate without underflow.
REQ-023 On each edge in PRESS with sealed && !abort, Pressure SHALL become min(Pressure+STEP, PRESS_MAX).
REQ-024 On the edge where Pressure reaches its target (0 or PRESS_MAX), the state SHALL become IDLE and done SHALL be 1 for exactly the following cycle.
REQ-025 In EVAC or PRESS, if !sealed is sampled, the state SHALL become FAULT and Pressure SHALL be unchanged on that edge; door loss takes priority over abort.
REQ-026 In EVAC or PRESS with sealed && abort, the state SHALL become IDLE, Pressure SHALL be held, and done SHALL NOT pulse.
REQ-027 In FAULT, the state SHALL become IDLE only when fault_clear && sealed; Pressure SHALL be held throughout FAULT.
REQ-028 Request inputs SHALL be level-sensitive: a request held after done SHALL NOT restart, because the target flag is already set.
REQ-029 Latency from request to the first pressure change SHALL be 2 edges: one edge to enter the state, the next edge updates Pressure.

Reset
REQ-030 While Reset is high, asynchronously: state SHALL be IDLE, Pressure SHALL be PRESS_MAX, and done, Fault, Evacuation and Pressurization SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL abandon the operation without a done pulse.

Structure
REQ-032 Package airlock_pkg SHALL hold the state enum and the default PRESS_W, PRESS_MAX and STEP constants.
REQ-033 The saturating up/down pressure register SHALL be the sub-module pressure_counter, with inputs inc, dec, step and max, and output value.

Verification
REQ-034 Defaults, sealed, 1-cycle begin_Evacuation -> Evacuation high for 40 cycles, Pressure 200->0, done pulses once, Evacuated=1.
REQ-035 STEP=7 override, evacuate from 200 -> 29 active cycles, final Pressure 0 (last step saturates from 4), no wrap.
REQ-036 OuterClosed drops at Pressure=120 during EVAC -> Fault=1, Pressure stays 120; fault_clear while open -> stays FAULT; close and assert fault_clear -> IDLE.
REQ-037 abort at Pressure=100 during PRESS from 0 -> IDLE, Pressure 100, no done; begin_Pressurization again -> resumes to 200 in 20 cycles.
REQ-038 Both begin_* asserted together in IDLE -> stays IDLE, outputs unchanged.
REQ-039 Reset asserted mid-EVAC at Pressure=50 -> immediately IDLE, Pressure=200, no done pulse.
